// File: rtl/walk_pkg.sv
// ============================================================================
// Module      : walk_pkg
// Description : Shared FSM state type and channel-index width helper for the
//               walk-request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package walk_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // A single channel still needs a 1-bit index so grant_ch never collapses.
    function automatic int calc_ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/walk_request_arbiter_if.sv
// ============================================================================
// Module      : walk_request_arbiter_if
// Description : Request/clear/grant bundle between the light sequencer
//               (master) and the walk-request arbiter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface walk_request_arbiter_if
    import walk_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CH_W   = calc_ch_w(NUM_CH)
) ();

    logic [NUM_CH-1:0] req_sync;
    logic              clr_all;
    logic [NUM_CH-1:0] clr_ch;
    logic              grant_ack;
    logic [NUM_CH-1:0] pending;
    logic              any_pending;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_ch;
    logic [NUM_CH-1:0] starve;

    modport master (
        output req_sync, clr_all, clr_ch, grant_ack,
        input  pending, any_pending, grant_valid, grant_ch, starve
    );

    modport slave (
        input  req_sync, clr_all, clr_ch, grant_ack,
        output pending, any_pending, grant_valid, grant_ch, starve
    );

endinterface

`default_nettype wire

// File: rtl/walk_ch_latch.sv
// ============================================================================
// Module      : walk_ch_latch
// Description : One walk channel: button edge detect, pending flop, saturating
//               wait counter and registered starvation flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module walk_ch_latch #(
    parameter int EDGE_MODE = 1,
    parameter int WAIT_W    = 8,
    parameter int MAX_WAIT  = 200
) (
    input  logic clk,
    input  logic g_reset,
    input  logic req_sync,
    input  logic clr_all,
    input  logic clr_ch,
    input  logic ack_clr,
    output logic pending,
    output logic starve
);

    logic              r_req_prev;
    logic              r_pending;
    logic              r_starve;
    logic [WAIT_W-1:0] r_wait;
    logic              w_set;

    assign w_set = (EDGE_MODE != 0) ? (req_sync & ~r_req_prev) : req_sync;

    // req_prev resets high so a button held through reset must be re-pressed.
    always_ff @(posedge clk or negedge g_reset) begin
        if (!g_reset) begin
            r_req_prev <= 1'b1;
            r_pending  <= 1'b0;
            r_wait     <= '0;
            r_starve   <= 1'b0;
        end else begin
            r_req_prev <= req_sync;

            if (clr_all || clr_ch) begin
                r_pending <= 1'b0;
            end else if (w_set) begin
                r_pending <= 1'b1;
            end else if (ack_clr) begin
                r_pending <= 1'b0;
            end

            if (!r_pending) begin
                r_wait <= '0;
            end else if (r_wait != {WAIT_W{1'b1}}) begin
                r_wait <= r_wait + 1'b1;
            end

            // Gating with pending drops starve one edge after service.
            r_starve <= r_pending && (r_wait >= WAIT_W'(MAX_WAIT));
        end
    end

    assign pending = r_pending;
    assign starve  = r_starve;

endmodule

`default_nettype wire

// File: rtl/walk_request_arbiter.sv
// ============================================================================
// Module      : walk_request_arbiter
// Description : Latches pedestrian walk requests and offers them one at a time
//               to the light sequencer with round-robin fairness.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module walk_request_arbiter
    import walk_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int EDGE_MODE = 1,
    parameter int WAIT_W    = 8,
    parameter int MAX_WAIT  = 200
) (
    input  logic                   clk,
    input  logic                   g_reset,
    walk_request_arbiter_if.slave  bus
);

    localparam int CH_W = calc_ch_w(NUM_CH);

    state_t            r_state;
    logic              r_grant_valid;
    logic [CH_W-1:0]   r_grant_ch;
    logic [CH_W-1:0]   r_last_grant;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_starve;
    logic [NUM_CH-1:0] w_ack_clr;
    logic [CH_W-1:0]   w_idx;
    logic [CH_W-1:0]   w_pick;
    logic              w_found;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_ack_clr[gi] = r_grant_valid & bus.grant_ack & (r_grant_ch == CH_W'(gi));

        walk_ch_latch #(
            .EDGE_MODE (EDGE_MODE),
            .WAIT_W    (WAIT_W),
            .MAX_WAIT  (MAX_WAIT)
        ) u_latch (
            .clk      (clk),
            .g_reset  (g_reset),
            .req_sync (bus.req_sync[gi]),
            .clr_all  (bus.clr_all),
            .clr_ch   (bus.clr_ch[gi]),
            .ack_clr  (w_ack_clr[gi]),
            .pending  (w_pending[gi]),
            .starve   (w_starve[gi])
        );
    end

    // Scan starts just after the last served channel and wraps around.
    always_comb begin
        w_idx   = '0;
        w_pick  = '0;
        w_found = 1'b0;
        for (int off = 1; off <= NUM_CH; off++) begin
            w_idx = CH_W'((int'(r_last_grant) + off) % NUM_CH);
            if (!w_found && w_pending[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge g_reset) begin
        if (!g_reset) begin
            r_state       <= IDLE;
            r_grant_valid <= 1'b0;
            r_grant_ch    <= '0;
            r_last_grant  <= CH_W'(NUM_CH - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant_ch    <= w_pick;
                        r_grant_valid <= 1'b1;
                        r_state       <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.grant_ack) begin
                        r_grant_valid <= 1'b0;
                        r_last_grant  <= r_grant_ch;
                        r_state       <= IDLE;
                    end else if (bus.clr_all || bus.clr_ch[r_grant_ch]) begin
                        r_grant_valid <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_grant_valid <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.pending     = w_pending;
    assign bus.any_pending = |w_pending;
    assign bus.starve      = w_starve;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_ch    = r_grant_ch;

endmodule

`default_nettype wire

// File: tb/tb_walk_request_arbiter.sv
// ============================================================================
// Module      : tb_walk_request_arbiter
// Description : Self-checking bench for the walk-request arbiter, edge-mode and
//               level-mode instances side by side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_walk_request_arbiter;

    localparam int N   = 4;
    localparam int WW  = 4;
    localparam int MW  = 10;
    localparam int SAT = 15;

    logic clk     = 1'b0;
    logic g_reset = 1'b0;

    always #5 clk = ~clk;

    walk_request_arbiter_if #(.NUM_CH(N)) bus_e ();
    walk_request_arbiter_if #(.NUM_CH(N)) bus_l ();

    walk_request_arbiter #(.NUM_CH(N), .EDGE_MODE(1), .WAIT_W(WW), .MAX_WAIT(MW)) dut_e (
        .clk     (clk),
        .g_reset (g_reset),
        .bus     (bus_e)
    );

    walk_request_arbiter #(.NUM_CH(N), .EDGE_MODE(0), .WAIT_W(WW), .MAX_WAIT(MW)) dut_l (
        .clk     (clk),
        .g_reset (g_reset),
        .bus     (bus_l)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: index 0 = edge mode, 1 = level mode
    logic [3:0] m_pend[2];
    logic [3:0] m_prev[2];
    logic [3:0] m_starve[2];
    int         m_wait[2][4];
    bit         m_gv[2];
    int         m_gch[2];
    int         m_last[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0; m_prev[d] = '1; m_starve[d] = '0;
            m_gv[d] = 1'b0; m_gch[d] = 0; m_last[d] = N - 1;
            for (int i = 0; i < N; i++) m_wait[d][i] = 0;
        end
    endtask

    task automatic step(input int d, input logic [3:0] req, input logic ca,
                        input logic [3:0] cc, input logic ack);
        logic [3:0] np;
        bit set_i, ack_i;
        np = '0;
        for (int i = 0; i < N; i++) begin
            set_i = (d == 0) ? (req[i] && !m_prev[d][i]) : req[i];
            ack_i = m_gv[d] && ack && (m_gch[d] == i);
            if (ca || cc[i])  np[i] = 1'b0;
            else if (set_i)   np[i] = 1'b1;
            else if (ack_i)   np[i] = 1'b0;
            else              np[i] = m_pend[d][i];
            m_starve[d][i] = m_pend[d][i] && (m_wait[d][i] >= MW);
            m_wait[d][i]   = m_pend[d][i] ? ((m_wait[d][i] < SAT) ? m_wait[d][i] + 1 : SAT) : 0;
        end
        if (m_gv[d]) begin
            if (ack) begin
                m_gv[d] = 1'b0;
                m_last[d] = m_gch[d];
            end else if (ca || cc[m_gch[d]]) begin
                m_gv[d] = 1'b0;
            end
        end else begin
            for (int off = 1; off <= N; off++) begin
                int c;
                c = (m_last[d] + off) % N;
                if (!m_gv[d] && m_pend[d][c]) begin
                    m_gv[d] = 1'b1;
                    m_gch[d] = c;
                end
            end
        end
        m_pend[d] = np;
        m_prev[d] = req;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge g_reset);
            if (!g_reset) begin
                model_reset();
            end else begin
                step(0, bus_e.req_sync, bus_e.clr_all, bus_e.clr_ch, bus_e.grant_ack);
                step(1, bus_l.req_sync, bus_l.clr_all, bus_l.clr_ch, bus_l.grant_ack);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("e_pending",     bus_e.pending,     m_pend[0]);
            check("e_any_pending", bus_e.any_pending, m_pend[0] != 0);
            check("e_grant_valid", bus_e.grant_valid, m_gv[0]);
            check("e_grant_ch",    bus_e.grant_ch,    m_gch[0]);
            check("e_starve",      bus_e.starve,      m_starve[0]);
            check("l_pending",     bus_l.pending,     m_pend[1]);
            check("l_any_pending", bus_l.any_pending, m_pend[1] != 0);
            check("l_grant_valid", bus_l.grant_valid, m_gv[1]);
            check("l_grant_ch",    bus_l.grant_ch,    m_gch[1]);
            check("l_starve",      bus_l.starve,      m_starve[1]);
        end
    end

    // ---------------- directed stimulus with literal expectations
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        g_reset = 1'b0;
        cyc(1);
        g_reset = 1'b1;
        cyc(1);
    endtask

    task automatic serve(input int ch);
        check("serve_gv", bus_e.grant_valid, 1);
        check("serve_ch", bus_e.grant_ch, ch);
        cyc(1);
        bus_e.grant_ack = 1'b1;
        cyc(1);
        bus_e.grant_ack = 1'b0;
        check("serve_gap", bus_e.grant_valid, 0);
        cyc(1);
    endtask

    initial begin
        bus_e.req_sync = 4'b0010; bus_e.clr_all = 1'b0; bus_e.clr_ch = '0; bus_e.grant_ack = 1'b0;
        bus_l.req_sync = 4'b0000; bus_l.clr_all = 1'b0; bus_l.clr_ch = '0; bus_l.grant_ack = 1'b0;

        // Reset with a button held: no fire until re-pressed
        cyc(3);
        check("rst_pending", bus_e.pending, 4'b0000);
        check("rst_gv", bus_e.grant_valid, 0);
        check("rst_starve", bus_e.starve, 4'b0000);
        g_reset = 1'b1;
        cyc(5);
        check("held_no_fire", bus_e.pending, 4'b0000);
        bus_e.req_sync = 4'b0000;
        cyc(1);
        bus_e.req_sync = 4'b0010;
        cyc(1);
        check("press_pending", bus_e.pending, 4'b0010);
        check("press_gv_low", bus_e.grant_valid, 0);
        bus_e.req_sync = 4'b0000;
        cyc(1);
        check("first_gv", bus_e.grant_valid, 1);
        check("first_ch", bus_e.grant_ch, 1);
        bus_e.grant_ack = 1'b1;
        cyc(1);
        bus_e.grant_ack = 1'b0;
        check("ack_gv", bus_e.grant_valid, 0);
        check("ack_pending", bus_e.pending, 4'b0000);
        cyc(1);

        // Round robin 0,1,3
        do_reset();
        bus_e.req_sync = 4'b1011;
        cyc(1);
        bus_e.req_sync = 4'b0000;
        cyc(1);
        serve(0);
        serve(1);
        serve(3);
        check("rr_done", bus_e.pending, 4'b0000);

        // Withdraw an offer; last_grant must stay at 3
        do_reset();
        bus_e.req_sync = 4'b0100;
        cyc(1);
        bus_e.req_sync = 4'b0000;
        cyc(1);
        check("wd_ch", bus_e.grant_ch, 2);
        bus_e.clr_ch = 4'b0100;
        cyc(1);
        bus_e.clr_ch = 4'b0000;
        check("wd_gv", bus_e.grant_valid, 0);
        check("wd_pending", bus_e.pending, 4'b0000);
        bus_e.req_sync = 4'b1001;
        cyc(1);
        bus_e.req_sync = 4'b0000;
        cyc(1);
        serve(0);
        serve(3);

        // clr_all beats a set; a set beats its own ack
        bus_e.clr_all = 1'b1;
        bus_e.req_sync = 4'b1000;
        cyc(1);
        bus_e.clr_all = 1'b0;
        bus_e.req_sync = 4'b0000;
        check("clrall_pending", bus_e.pending, 4'b0000);
        cyc(1);
        bus_e.req_sync = 4'b1000;
        cyc(1);
        bus_e.req_sync = 4'b0000;
        cyc(1);
        check("cp_ch", bus_e.grant_ch, 3);
        bus_e.grant_ack = 1'b1;
        bus_e.req_sync = 4'b1000;
        cyc(1);
        bus_e.grant_ack = 1'b0;
        bus_e.req_sync = 4'b0000;
        check("ackset_pending", bus_e.pending, 4'b1000);
        check("ackset_gv", bus_e.grant_valid, 0);
        cyc(1);
        check("reoffer_gv", bus_e.grant_valid, 1);
        check("reoffer_ch", bus_e.grant_ch, 3);
        bus_e.grant_ack = 1'b1;
        cyc(1);
        bus_e.grant_ack = 1'b0;
        cyc(1);

        // Starvation and counter saturation
        bus_e.req_sync = 4'b0001;
        cyc(1);
        bus_e.req_sync = 4'b0000;
        cyc(10);
        check("starve_pre", bus_e.starve, 4'b0000);
        cyc(1);
        check("starve_rise", bus_e.starve, 4'b0001);
        cyc(9);
        check("starve_sat", bus_e.starve, 4'b0001);
        bus_e.grant_ack = 1'b1;
        cyc(1);
        bus_e.grant_ack = 1'b0;
        check("starve_ack_pending", bus_e.pending, 4'b0000);
        check("starve_hold", bus_e.starve, 4'b0001);
        cyc(1);
        check("starve_fall", bus_e.starve, 4'b0000);

        // Asynchronous reset in the middle of an offer
        bus_e.req_sync = 4'b0110;
        cyc(1);
        bus_e.req_sync = 4'b0000;
        cyc(1);
        check("mid_ch", bus_e.grant_ch, 1);
        #1;
        g_reset = 1'b0;
        #1;
        check("async_gv", bus_e.grant_valid, 0);
        check("async_pending", bus_e.pending, 4'b0000);
        cyc(1);
        g_reset = 1'b1;
        cyc(1);
        bus_e.req_sync = 4'b1100;
        cyc(1);
        bus_e.req_sync = 4'b0000;
        cyc(1);
        check("post_rst_ch", bus_e.grant_ch, 2);
        bus_e.grant_ack = 1'b1;
        cyc(1);
        bus_e.grant_ack = 1'b0;
        cyc(1);
        bus_e.grant_ack = 1'b1;
        cyc(1);
        bus_e.grant_ack = 1'b0;
        cyc(1);

        // Level mode: held request survives its ack and is offered again
        bus_l.req_sync = 4'b0001;
        cyc(1);
        check("lvl_pending", bus_l.pending, 4'b0001);
        cyc(1);
        check("lvl_gv", bus_l.grant_valid, 1);
        check("lvl_ch", bus_l.grant_ch, 0);
        bus_l.grant_ack = 1'b1;
        cyc(1);
        bus_l.grant_ack = 1'b0;
        check("lvl_ack_pending", bus_l.pending, 4'b0001);
        check("lvl_ack_gv", bus_l.grant_valid, 0);
        cyc(1);
        check("lvl_reoffer", bus_l.grant_valid, 1);
        bus_l.req_sync = 4'b0000;
        bus_l.grant_ack = 1'b1;
        cyc(1);
        bus_l.grant_ack = 1'b0;
        check("lvl_done", bus_l.pending, 4'b0000);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/walk_request_arbiter.md
# walk_request_arbiter

Parametrised pedestrian walk-request register for the traffic-light controller. It latches up to NUM_CH synchronised push-button requests and holds each one until it is serviced or cleared. It offers one pending channel at a time to the light sequencer through a valid/ack grant handshake with round-robin fairness, and flags any request that has waited too long.

## Interface
- NUM_CH, 2: number of walk channels (1..16)
- EDGE_MODE, 1: 1 = latch on rising edge of req_sync; 0 = latch while req_sync is high
- WAIT_W, 8: width of each per-channel wait counter
- MAX_WAIT, 200: wait-cycle threshold for starve; must be < 2^WAIT_W
- CH_W, max(1, clog2(NUM_CH)): derived channel-index width
- clk  in  1  system clock, all logic on rising edge
- g_reset  in  1  asynchronous, active-low global reset
- req_sync  in  NUM_CH  already-synchronised button levels
- clr_all  in  1  synchronous clear of all pending requests
- clr_ch  in  NUM_CH  synchronous per-channel clear
- grant_ack  in  1  sequencer accepts the offered channel
- pending  out  NUM_CH  latched requests
- any_pending  out  1  OR of pending
- grant_valid  out  1  a channel is being offered
- grant_ch  out  CH_W  offered channel index
- starve  out  NUM_CH  channel wait count >= MAX_WAIT

## Operation
- Reset values: pending=0, any_pending=0, grant_valid=0, grant_ch=0, starve=0, wait counters=0, last_grant=NUM_CH-1, req_prev=all ones. A button held through reset does not fire in edge mode until it is released and pressed again.
- Set condition for channel i: EDGE_MODE=1 requires req_sync[i]=1 and req_prev[i]=0. EDGE_MODE=0 requires req_sync[i]=1.
- Per-channel update priority, highest first: clr_all, then clr_ch[i], then set, then ack-clear (grant_valid & grant_ack & grant_ch==i), then hold. A new set on the same edge as its own ack keeps the channel pending.
- FSM states are IDLE and OFFER.
- IDLE: if any_pending, pick the first pending channel scanning last_grant+1, +2, … modulo NUM_CH. Register it into grant_ch, set grant_valid=1 and go to OFFER. Otherwise stay.
- OFFER: grant_ch is frozen.
  - On grant_ack: grant_valid←0, last_grant←grant_ch, go to IDLE.
  - If pending[grant_ch] is cleared by clr_all or clr_ch without an ack: grant_valid←0, go to IDLE, last_grant unchanged.
  - If ack and clear arrive together, treat it as ack.
- grant_ack is ignored while grant_valid=0.
- Wait counter i is forced to 0 when pending[i]=0. Otherwise it increments by 1 per cycle and saturates at 2^WAIT_W-1 (no wrap).
- starve[i] is registered: counter_i >= MAX_WAIT.

## Timing
- req_sync rising edge sampled at edge k: pending high after edge k, grant_valid high after edge k+1 (from IDLE).
- Ack sampled at edge m: pending[grant_ch] low and grant_valid low after edge m. The earliest next grant_valid is after edge m+1, so there is a mandatory one-cycle idle gap.
- Clear inputs take effect at the sampling edge. A withdrawn offer drops grant_valid at that same edge.
- starve asserts MAX_WAIT+1 edges after pending rises (counter and compare are both registered). It deasserts on the edge after pending falls.
- g_reset assertion mid-OFFER: all outputs drop immediately (asynchronous). After release, the first grant goes to the lowest pending channel.

## Structure
- Package walk_pkg holds the FSM state enum (IDLE, OFFER) and a clog2-based CH_W helper function.
- Sub-module walk_ch_latch holds one channel's edge detect, pending flop, wait counter and starve compare. It is instantiated NUM_CH times by generate.
- The round-robin picker and FSM live in the top level.

## Test plan
All scenarios use NUM_CH=4, EDGE_MODE=1, WAIT_W=4, MAX_WAIT=10 unless noted.
- Reset/hold: g_reset low 3 cycles with req_sync=4'b0010 held, release, keep held 5 cycles -> pending stays 0. Then drop and raise req_sync[1] -> pending=4'b0010 after 1 edge, grant_valid=1, grant_ch=1 after 2 edges.
- Round-robin: pulse req_sync=4'b1011 at once, ack every offer 2 cycles after grant_valid -> grant_ch sequence 0,1,3, with a one-cycle grant_valid low gap between offers.
- Withdraw: offer on ch2, assert clr_ch=4'b0100 without ack -> grant_valid low next edge, pending[2]=0. A later request on ch0 is offered before ch2's next request (last_grant unchanged).
- Clear priority: clr_all on the same edge as a new rising req_sync[3] -> pending[3]=0. Separately, ack ch3 on the same edge as a new req_sync[3] edge -> pending[3] stays 1 and is re-offered.
- Starvation/saturation: hold one pending request unacked 20 cycles -> starve rises exactly 11 edges after pending rises, counter reads 15 and does not wrap. Ack -> starve low 1 edge later.
- Level mode (EDGE_MODE=0): hold req_sync[0]=1 through an ack -> pending[0] re-asserts the edge after the ack and is offered again.
